mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one request per load/store,
// holds the pipeline until completion, and retires results/errors to MEM/WB.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        wb_wreg,
  output logic [4:0]  wb_wd,
  output logic [31:0] wb_wdata,
  output logic        stall_req,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] bad_vaddr
);
  localparam logic [7:0] OP_LB = 8'hE0, OP_LH = 8'hE1, OP_LW = 8'hE3, OP_LBU = 8'hE4,
                         OP_LHU = 8'hE5, OP_SB = 8'hE8, OP_SH = 8'hE9, OP_SW = 8'hEB;
  localparam logic [7:0] WDOG_LAST = 8'd254;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic        dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic        wb_valid_q, wb_valid_d, wb_wreg_q, wb_wreg_d;
  logic [4:0]  wb_wd_q, wb_wd_d, wd_q, wd_d;
  logic        wreg_q, wreg_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic        addr_err_q, addr_err_d, bus_err_q, bus_err_d;
  logic [31:0] bad_vaddr_q, bad_vaddr_d;

  logic        is_mem, is_store, misaligned, op_q_store;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  always_comb begin
    is_mem   = 1'b0;
    is_store = 1'b0;
    case (mem_aluop)
      OP_LB, OP_LBU:  is_mem = 1'b1;
      OP_LH, OP_LHU:  is_mem = 1'b1;
      OP_LW:          is_mem = 1'b1;
      OP_SB, OP_SH, OP_SW: begin is_mem = 1'b1; is_store = 1'b1; end
      default: ;
    endcase
    misaligned = ((mem_aluop == OP_LH || mem_aluop == OP_LHU || mem_aluop == OP_SH) && mem_mem_addr[0])
              || ((mem_aluop == OP_LW || mem_aluop == OP_SW) && (mem_mem_addr[1:0] != 2'b00));
  end

  // Combinational so EX/MEM freezes in the same cycle the access is seen.
  assign stall_req = ~rst & in_valid & is_mem & (state_q != DONE) & ~misaligned;

  // Little-endian lane extraction for the retiring load.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    rd_byte = dm_rdata[7:0];
      2'd1:    rd_byte = dm_rdata[15:8];
      2'd2:    rd_byte = dm_rdata[23:16];
      default: rd_byte = dm_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'h0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'h0, rd_half};
      default: load_data = dm_rdata;
    endcase
    op_q_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
  end

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_be_d     = dm_be_q;
    dm_wdata_d  = dm_wdata_q;
    wb_valid_d  = 1'b0;
    wb_wreg_d   = wb_wreg_q;
    wb_wd_d     = wb_wd_q;
    wb_wdata_d  = wb_wdata_q;
    addr_err_d  = 1'b0;
    bus_err_d   = 1'b0;
    bad_vaddr_d = bad_vaddr_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (!is_mem) begin
          wb_valid_d = 1'b1;
          wb_wd_d    = mem_wd;
          wb_wreg_d  = mem_wreg;
          wb_wdata_d = mem_wdata;
        end else if (misaligned) begin
          wb_valid_d  = 1'b1;
          wb_wd_d     = mem_wd;
          wb_wreg_d   = 1'b0;
          wb_wdata_d  = 32'h0;
          addr_err_d  = 1'b1;
          bad_vaddr_d = mem_mem_addr;
        end else begin
          state_d    = BUSY;
          wdog_d     = 8'd0;
          op_d       = mem_aluop;
          addr_d     = mem_mem_addr;
          wd_d       = mem_wd;
          wreg_d     = mem_wreg & ~is_store;
          dm_req_d   = 1'b1;
          dm_we_d    = is_store;
          dm_addr_d  = {mem_mem_addr[31:2], 2'b00};
          dm_be_d    = 4'b1111;
          dm_wdata_d = mem_reg2;
          if (mem_aluop == OP_SB) begin
            dm_be_d    = 4'b0001 << mem_mem_addr[1:0];
            dm_wdata_d = {4{mem_reg2[7:0]}};
          end else if (mem_aluop == OP_SH) begin
            dm_be_d    = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
            dm_wdata_d = {2{mem_reg2[15:0]}};
          end
        end
      end
      BUSY: begin
        // Ack takes priority over a watchdog expiry on the same edge.
        if (dm_ack) begin
          state_d    = DONE;
          dm_req_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_wd_d    = wd_q;
          wb_wreg_d  = wreg_q & ~op_q_store;
          wb_wdata_d = load_data;
        end else if (wdog_q == WDOG_LAST) begin
          state_d     = DONE;
          dm_req_d    = 1'b0;
          wb_valid_d  = 1'b1;
          wb_wd_d     = wd_q;
          wb_wreg_d   = 1'b0;
          bus_err_d   = 1'b1;
          bad_vaddr_d = addr_q;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wdog_q      <= 8'd0;
      op_q        <= 8'd0;
      addr_q      <= 32'h0;
      wd_q        <= 5'd0;
      wreg_q      <= 1'b0;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= 32'h0;
      dm_be_q     <= 4'h0;
      dm_wdata_q  <= 32'h0;
      wb_valid_q  <= 1'b0;
      wb_wreg_q   <= 1'b0;
      wb_wd_q     <= 5'd0;
      wb_wdata_q  <= 32'h0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      bad_vaddr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_be_q     <= dm_be_d;
      dm_wdata_q  <= dm_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_wreg_q   <= wb_wreg_d;
      wb_wd_q     <= wb_wd_d;
      wb_wdata_q  <= wb_wdata_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
      bad_vaddr_q <= bad_vaddr_d;
    end
  end

  assign dm_req    = dm_req_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_be     = dm_be_q;
  assign dm_wdata  = dm_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_wreg   = wb_wreg_q;
  assign wb_wd     = wb_wd_q;
  assign wb_wdata  = wb_wdata_q;
  assign addr_err  = addr_err_q;
  assign bus_err   = bus_err_q;
  assign bad_vaddr = bad_vaddr_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: ALU passthrough, loads/stores, misalignment,
// watchdog, ack/watchdog tie, and reset during an outstanding access.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst, in_valid, mem_wreg, dm_ack;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_mem_addr, mem_reg2, dm_rdata;
  logic [7:0]  mem_aluop;
  logic        dm_req, dm_we, wb_valid, wb_wreg, stall_req, addr_err, bus_err;
  logic [31:0] dm_addr, dm_wdata, wb_wdata, bad_vaddr;
  logic [3:0]  dm_be;
  logic [4:0]  wb_wd;
  int pass_cnt = 0;
  int total = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .stall_req(stall_req), .addr_err(addr_err), .bus_err(bus_err), .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    in_valid = 1'b1; mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; mem_aluop = 8'h00; dm_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(8'hE3, 32'h0000_1000, 32'h0, 5'd1, 1'b1, 32'h0);
    total++; if (stall_req !== 1'b0) $display("FAIL rst_stall got=%0h exp=0", stall_req); else pass_cnt++;
    tick(); tick();
    total++; if (dm_req !== 1'b0) $display("FAIL rst_dm_req got=%0h exp=0", dm_req); else pass_cnt++;
    total++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid got=%0h exp=0", wb_valid); else pass_cnt++;
    total++; if ({addr_err, bus_err} !== 2'b00) $display("FAIL rst_errs got=%0h exp=0", {addr_err, bus_err}); else pass_cnt++;
    total++; if (bad_vaddr !== 32'h0) $display("FAIL rst_bad_vaddr got=%0h exp=0", bad_vaddr); else pass_cnt++;
    total++; if (dm_addr !== 32'h0 || dm_be !== 4'h0 || wb_wdata !== 32'h0) $display("FAIL rst_fields got=%0h/%0h/%0h exp=0", dm_addr, dm_be, wb_wdata); else pass_cnt++;
    rst = 1'b0; idle_in(); tick();
  endtask

  task automatic test_alu();
    drive(8'h21, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234);
    total++; if (stall_req !== 1'b0) $display("FAIL alu_stall got=%0h exp=0", stall_req); else pass_cnt++;
    tick();
    total++; if (wb_valid !== 1'b1 || wb_wd !== 5'd5 || wb_wreg !== 1'b1) $display("FAIL alu_wb got=%0h/%0h/%0h exp=1/5/1", wb_valid, wb_wd, wb_wreg); else pass_cnt++;
    total++; if (wb_wdata !== 32'h0000_1234) $display("FAIL alu_wdata got=%0h exp=1234", wb_wdata); else pass_cnt++;
    total++; if (dm_req !== 1'b0) $display("FAIL alu_no_req got=%0h exp=0", dm_req); else pass_cnt++;
    idle_in(); tick();
    total++; if (wb_valid !== 1'b0) $display("FAIL alu_pulse got=%0h exp=0", wb_valid); else pass_cnt++;
  endtask

  task automatic test_lb();
    drive(8'hE0, 32'h0000_1003, 32'h0, 5'd9, 1'b1, 32'h0);
    total++; if (stall_req !== 1'b1) $display("FAIL lb_stall0 got=%0h exp=1", stall_req); else pass_cnt++;
    tick();
    total++; if (dm_req !== 1'b1 || dm_we !== 1'b0) $display("FAIL lb_req got=%0h/%0h exp=1/0", dm_req, dm_we); else pass_cnt++;
    total++; if (dm_addr !== 32'h0000_1000 || dm_be !== 4'b1111) $display("FAIL lb_addr_be got=%0h/%0h exp=1000/f", dm_addr, dm_be); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total++; if (dm_req !== 1'b1 || stall_req !== 1'b1 || wb_valid !== 1'b0) $display("FAIL lb_hold%0d got=%0h/%0h/%0h exp=1/1/0", i, dm_req, stall_req, wb_valid); else pass_cnt++;
      tick();
    end
    dm_ack = 1'b1; dm_rdata = 32'h8011_2233; #1;
    total++; if (stall_req !== 1'b1) $display("FAIL lb_stall_ack got=%0h exp=1", stall_req); else pass_cnt++;
    tick();
    dm_ack = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_wdata !== 32'hFFFF_FF80 || wb_wd !== 5'd9 || wb_wreg !== 1'b1) $display("FAIL lb_wb got=%0h/%0h/%0h/%0h exp=1/ffffff80/9/1", wb_valid, wb_wdata, wb_wd, wb_wreg); else pass_cnt++;
    total++; if (dm_req !== 1'b0 || stall_req !== 1'b0) $display("FAIL lb_done got=%0h/%0h exp=0/0", dm_req, stall_req); else pass_cnt++;
    idle_in(); tick();
    total++; if (wb_valid !== 1'b0) $display("FAIL lb_pulse got=%0h exp=0", wb_valid); else pass_cnt++;
  endtask

  task automatic test_sh();
    drive(8'hE9, 32'h0000_2002, 32'hABCD_1234, 5'd7, 1'b1, 32'h0);
    tick();
    total++; if (dm_be !== 4'b1100 || dm_wdata !== 32'h1234_1234) $display("FAIL sh_lane got=%0h/%0h exp=c/12341234", dm_be, dm_wdata); else pass_cnt++;
    total++; if (dm_we !== 1'b1 || dm_req !== 1'b1 || dm_addr !== 32'h0000_2000) $display("FAIL sh_req got=%0h/%0h/%0h exp=1/1/2000", dm_we, dm_req, dm_addr); else pass_cnt++;
    dm_ack = 1'b1; tick(); dm_ack = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_wreg !== 1'b0) $display("FAIL sh_wb got=%0h/%0h exp=1/0", wb_valid, wb_wreg); else pass_cnt++;
    // DONE cycle: same instruction still in EX/MEM; must release the stall and not re-issue
    total++; if (stall_req !== 1'b0) $display("FAIL sh_done_stall got=%0h exp=0", stall_req); else pass_cnt++;
    dm_ack = 1'b1; tick(); dm_ack = 1'b0;
    total++; if (dm_req !== 1'b0 || wb_valid !== 1'b0) $display("FAIL sh_done_req got=%0h/%0h exp=0/0", dm_req, wb_valid); else pass_cnt++;
    idle_in(); tick();
  endtask

  task automatic test_lanes();
    drive(8'hE8, 32'h0000_1001, 32'h0000_00AB, 5'd1, 1'b1, 32'h0); tick();
    total++; if (dm_be !== 4'b0010 || dm_wdata !== 32'hABAB_ABAB) $display("FAIL sb_lane got=%0h/%0h exp=2/abababab", dm_be, dm_wdata); else pass_cnt++;
    dm_ack = 1'b1; tick(); idle_in(); tick();
    drive(8'hE1, 32'h0000_1002, 32'h0, 5'd2, 1'b1, 32'h0); tick();
    dm_ack = 1'b1; dm_rdata = 32'h8011_2233; tick();
    total++; if (wb_wdata !== 32'hFFFF_8011) $display("FAIL lh_data got=%0h exp=ffff8011", wb_wdata); else pass_cnt++;
    idle_in(); tick();
    drive(8'hE4, 32'h0000_1001, 32'h0, 5'd3, 1'b1, 32'h0); tick();
    dm_ack = 1'b1; dm_rdata = 32'h8011_A233; tick();
    total++; if (wb_wdata !== 32'h0000_00A2) $display("FAIL lbu_data got=%0h exp=a2", wb_wdata); else pass_cnt++;
    idle_in(); tick();
    drive(8'hEB, 32'h0000_1004, 32'hDEAD_BEEF, 5'd4, 1'b1, 32'h0); tick();
    total++; if (dm_be !== 4'b1111 || dm_wdata !== 32'hDEAD_BEEF || dm_addr !== 32'h0000_1004) $display("FAIL sw_lane got=%0h/%0h/%0h exp=f/deadbeef/1004", dm_be, dm_wdata, dm_addr); else pass_cnt++;
    dm_ack = 1'b1; tick(); idle_in(); tick();
  endtask

  task automatic test_misaligned();
    drive(8'hE3, 32'h0000_3001, 32'h0, 5'd6, 1'b1, 32'h0);
    total++; if (stall_req !== 1'b0) $display("FAIL mis_stall got=%0h exp=0", stall_req); else pass_cnt++;
    tick();
    total++; if (addr_err !== 1'b1 || bad_vaddr !== 32'h0000_3001) $display("FAIL mis_err got=%0h/%0h exp=1/3001", addr_err, bad_vaddr); else pass_cnt++;
    total++; if (wb_valid !== 1'b1 || wb_wreg !== 1'b0 || dm_req !== 1'b0) $display("FAIL mis_wb got=%0h/%0h/%0h exp=1/0/0", wb_valid, wb_wreg, dm_req); else pass_cnt++;
    drive(8'hE5, 32'h0000_0005, 32'h0, 5'd6, 1'b1, 32'h0);
    total++; if (stall_req !== 1'b0) $display("FAIL mis_lhu_stall got=%0h exp=0", stall_req); else pass_cnt++;
    tick();
    total++; if (addr_err !== 1'b1 || bad_vaddr !== 32'h0000_0005 || dm_req !== 1'b0) $display("FAIL mis_lhu got=%0h/%0h/%0h exp=1/5/0", addr_err, bad_vaddr, dm_req); else pass_cnt++;
    idle_in(); tick();
    total++; if (addr_err !== 1'b0 || wb_valid !== 1'b0) $display("FAIL mis_pulse got=%0h/%0h exp=0/0", addr_err, wb_valid); else pass_cnt++;
  endtask

  task automatic test_ack_idle();
    dm_ack = 1'b1; dm_rdata = 32'h1111_1111; tick(); tick();
    total++; if (wb_valid !== 1'b0 || dm_req !== 1'b0) $display("FAIL ack_idle got=%0h/%0h exp=0/0", wb_valid, dm_req); else pass_cnt++;
    dm_ack = 1'b0;
  endtask

  task automatic test_watchdog();
    int cnt = 0;
    drive(8'hE3, 32'h0000_4000, 32'h0, 5'd3, 1'b1, 32'h0); tick();
    while (dm_req === 1'b1 && cnt < 300) begin
      if (bus_err !== 1'b0) begin total++; $display("FAIL wd_early cycle=%0d got=1 exp=0", cnt); end
      cnt++; tick();
    end
    total++; if (cnt !== 255) $display("FAIL wd_cycles got=%0d exp=255", cnt); else pass_cnt++;
    total++; if (bus_err !== 1'b1 || wb_valid !== 1'b1 || wb_wreg !== 1'b0) $display("FAIL wd_err got=%0h/%0h/%0h exp=1/1/0", bus_err, wb_valid, wb_wreg); else pass_cnt++;
    total++; if (bad_vaddr !== 32'h0000_4000 || dm_req !== 1'b0) $display("FAIL wd_vaddr got=%0h/%0h exp=4000/0", bad_vaddr, dm_req); else pass_cnt++;
    idle_in(); tick();
    total++; if (bus_err !== 1'b0) $display("FAIL wd_pulse got=%0h exp=0", bus_err); else pass_cnt++;
  endtask

  task automatic test_ack_wdog_tie();
    drive(8'hE3, 32'h0000_4100, 32'h0, 5'd8, 1'b1, 32'h0); tick();
    for (int i = 0; i < 254; i++) tick();
    dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D; tick(); dm_ack = 1'b0;
    total++; if (bus_err !== 1'b0 || wb_wreg !== 1'b1 || wb_wdata !== 32'hCAFE_F00D) $display("FAIL tie got=%0h/%0h/%0h exp=0/1/cafef00d", bus_err, wb_wreg, wb_wdata); else pass_cnt++;
    idle_in(); tick();
  endtask

  task automatic test_reset_busy();
    drive(8'hE3, 32'h0000_5000, 32'h0, 5'd4, 1'b1, 32'h0); tick(); tick();
    rst = 1'b1; #1;
    total++; if (stall_req !== 1'b0) $display("FAIL rb_stall got=%0h exp=0", stall_req); else pass_cnt++;
    tick();
    total++; if (dm_req !== 1'b0 || wb_valid !== 1'b0) $display("FAIL rb_drop got=%0h/%0h exp=0/0", dm_req, wb_valid); else pass_cnt++;
    rst = 1'b0;
    drive(8'hE5, 32'h0000_0000, 32'h0, 5'd10, 1'b1, 32'h0); tick();
    total++; if (dm_req !== 1'b1 || dm_addr !== 32'h0) $display("FAIL rb_lhu_req got=%0h/%0h exp=1/0", dm_req, dm_addr); else pass_cnt++;
    dm_ack = 1'b1; dm_rdata = 32'h0000_F00D; tick(); dm_ack = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_wdata !== 32'h0000_F00D || wb_wd !== 5'd10) $display("FAIL rb_lhu got=%0h/%0h/%0h exp=1/f00d/a", wb_valid, wb_wdata, wb_wd); else pass_cnt++;
    idle_in(); tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'h0;
    mem_aluop = 8'h0; mem_mem_addr = 32'h0; mem_reg2 = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;
    test_reset();
    test_alu();
    test_lb();
    test_sh();
    test_lanes();
    test_misaligned();
    test_ack_idle();
    test_watchdog();
    test_ack_wdog_tie();
    test_reset_busy();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
